scc_channel_sequencer: RTL and testbench



---
 rtl/scc_pkg.sv | 21 ++
 rtl/scc_register_file.sv | 113 +++++++++++
 rtl/scc_channel_sequencer.sv | 123 ++++++++++++
 tb/tb_scc_channel_sequencer.sv | 272 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/scc_pkg.sv
// Shared slot numbering and register address map for the SCC channel sequencer.
package scc_pkg;

    typedef logic [2:0] slot_t;

    localparam int FRAME_LEN = 6;
    localparam int NUM_CH    = 5;

    localparam slot_t SLOT_A   = 3'd0;
    localparam slot_t SLOT_B   = 3'd1;
    localparam slot_t SLOT_C   = 3'd2;
    localparam slot_t SLOT_D   = 3'd3;
    localparam slot_t SLOT_E   = 3'd4;
    localparam slot_t SLOT_CPU = 3'd5;

    localparam logic [7:0] FREQ_BASE   = 8'h80;
    localparam logic [7:0] VOL_BASE    = 8'h8A;
    localparam logic [7:0] ENABLE_ADDR = 8'h8F;
    localparam logic [7:0] MODE_ADDR   = 8'hE0;

endpackage

// File: rtl/scc_register_file.sv
// Channel register storage with per-slot output mux; the readback mux exists
// only when SCC_REG_READBACK_EN is defined.
module scc_register_file
    import scc_pkg::*;
(
    input  logic       clk,
    input  logic       reset,
    input  slot_t      active,
    input  logic       wr_en,
    input  logic [7:0] wr_address,
    input  logic [7:0] wr_data,
`ifdef SCC_REG_READBACK_EN
    input  logic [7:0] rd_address,
    output logic [7:0] rd_data,
`endif
    output logic [11:0] reg_frequency_count,
    output logic [3:0]  reg_volume,
    output logic        reg_enable,
    output logic        reg_wave_reset,
    output logic        reg_wave_error_en,
    output logic [4:0]  clear_counter
);

    logic [11:0] freq [NUM_CH];
    logic [3:0]  vol  [NUM_CH];
    logic [4:0]  enable;
    logic [1:0]  mode;
    logic [2:0]  wr_ch;
    logic        wr_freq;
    logic        wr_vol;

    always_comb begin
        wr_ch   = '0;
        wr_freq = wr_address >= FREQ_BASE && wr_address < FREQ_BASE + 8'd10;
        wr_vol  = wr_address >= VOL_BASE && wr_address < VOL_BASE + 8'd5;
        if (wr_freq) begin
            wr_ch = 3'((wr_address - FREQ_BASE) >> 1);
        end else if (wr_vol) begin
            wr_ch = 3'(wr_address - VOL_BASE);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < NUM_CH; i++) begin
                freq[i] <= '0;
                vol[i]  <= '0;
            end
            enable        <= '0;
            mode          <= '0;
            clear_counter <= '0;
        end else begin
            clear_counter <= '0;
            if (wr_en) begin
                if (wr_freq) begin
                    // either byte restarts that channel's counter, in step with the ack
                    clear_counter[wr_ch] <= 1'b1;
                    if (wr_address[0]) begin
                        freq[wr_ch][11:8] <= wr_data[3:0];
                    end else begin
                        freq[wr_ch][7:0] <= wr_data;
                    end
                end else if (wr_vol) begin
                    vol[wr_ch] <= wr_data[3:0];
                end else if (wr_address == ENABLE_ADDR) begin
                    enable <= wr_data[4:0];
                end else if (wr_address == MODE_ADDR) begin
                    mode <= wr_data[1:0];
                end
            end
        end
    end

    always_comb begin
        reg_frequency_count = '0;
        reg_volume          = '0;
        reg_enable          = 1'b0;
        if (active < SLOT_CPU) begin
            reg_frequency_count = freq[active];
            reg_volume          = vol[active];
            reg_enable          = enable[active];
        end
    end

    assign reg_wave_reset    = mode[0];
    assign reg_wave_error_en = mode[1];

`ifdef SCC_REG_READBACK_EN
    logic [2:0] rd_ch;

    // unused register bits read back as 1
    always_comb begin
        rd_data = 8'hFF;
        rd_ch   = '0;
        if (rd_address >= FREQ_BASE && rd_address < FREQ_BASE + 8'd10) begin
            rd_ch = 3'((rd_address - FREQ_BASE) >> 1);
            if (rd_address[0]) begin
                rd_data = {4'hF, freq[rd_ch][11:8]};
            end else begin
                rd_data = freq[rd_ch][7:0];
            end
        end else if (rd_address >= VOL_BASE && rd_address < VOL_BASE + 8'd5) begin
            rd_ch   = 3'(rd_address - VOL_BASE);
            rd_data = {4'hF, vol[rd_ch]};
        end else if (rd_address == ENABLE_ADDR) begin
            rd_data = {3'b111, enable};
        end else if (rd_address == MODE_ADDR) begin
            rd_data = {6'h3F, mode};
        end
    end
`endif

endmodule

// File: rtl/scc_channel_sequencer.sv
// Six-slot channel sequencer: five tone channels then one CPU slot sharing the wave RAM.
// Optional macro SCC_REG_READBACK_EN enables register readback.
module scc_channel_sequencer
    import scc_pkg::*;
(
    input  logic        clk,
    input  logic        reset,
    output logic [2:0]  active,
    input  logic [4:0]  wave_address,
    output logic [11:0] reg_frequency_count,
    output logic [3:0]  reg_volume,
    output logic        reg_enable,
    output logic        reg_wave_reset,
    output logic        reg_wave_error_en,
    output logic        clear_counter_a,
    output logic        clear_counter_b,
    output logic        clear_counter_c,
    output logic        clear_counter_d,
    output logic        clear_counter_e,
    input  logic        cpu_req,
    input  logic        cpu_we,
    input  logic [7:0]  cpu_address,
    input  logic [7:0]  cpu_wdata,
    output logic [7:0]  cpu_rdata,
    output logic        cpu_ack,
    output logic [6:0]  ram_address,
    output logic        ram_we,
    output logic [7:0]  ram_wdata,
    input  logic [7:0]  ram_rdata
);

    logic       grant;
    logic       vld_p1;
    logic       we_p1;
    logic       reg_p1;
    logic [7:0] reg_rdata;
    logic [4:0] clear_counter;

    // reset wins over a grant in the same cycle
    assign grant = !reset && active == SLOT_CPU && cpu_req && !vld_p1;

    always_ff @(posedge clk) begin
        if (reset) begin
            active <= SLOT_A;
            vld_p1 <= 1'b0;
        end else begin
            active <= (active == SLOT_CPU) ? SLOT_A : active + 3'd1;
            vld_p1 <= grant;
        end
    end

    // grant -> ack stage boundary
    always_ff @(posedge clk) begin
        if (grant) begin
            we_p1  <= cpu_we;
            reg_p1 <= cpu_address[7];
        end
    end

`ifdef SCC_REG_READBACK_EN
    logic [7:0] addr_p1;

    always_ff @(posedge clk) begin
        if (grant) begin
            addr_p1 <= cpu_address;
        end
    end
`else
    assign reg_rdata = 8'hFF;
`endif

    scc_register_file u_register_file (
        .clk                 (clk),
        .reset               (reset),
        .active              (active),
        .wr_en               (grant && cpu_we && cpu_address[7]),
        .wr_address          (cpu_address),
        .wr_data             (cpu_wdata),
`ifdef SCC_REG_READBACK_EN
        .rd_address          (addr_p1),
        .rd_data             (reg_rdata),
`endif
        .reg_frequency_count (reg_frequency_count),
        .reg_volume          (reg_volume),
        .reg_enable          (reg_enable),
        .reg_wave_reset      (reg_wave_reset),
        .reg_wave_error_en   (reg_wave_error_en),
        .clear_counter       (clear_counter)
    );

    assign clear_counter_a = clear_counter[0];
    assign clear_counter_b = clear_counter[1];
    assign clear_counter_c = clear_counter[2];
    assign clear_counter_d = clear_counter[3];
    assign clear_counter_e = clear_counter[4];
    assign cpu_ack         = vld_p1;

    // wave RAM answers one cycle after the grant, which is the ack cycle
    always_comb begin
        cpu_rdata = '0;
        if (vld_p1 && !we_p1) begin
            cpu_rdata = reg_p1 ? reg_rdata : ram_rdata;
        end
    end

    always_comb begin
        ram_address = '0;
        ram_we      = 1'b0;
        ram_wdata   = '0;
        case (active)
            SLOT_E: ram_address = {2'd3, wave_address};
            SLOT_CPU: begin
                if (grant && !cpu_address[7]) begin
                    ram_address = cpu_address[6:0];
                    ram_we      = cpu_we;
                    ram_wdata   = cpu_we ? cpu_wdata : 8'h00;
                end
            end
            default: ram_address = {active[1:0], wave_address};
        endcase
    end

endmodule

// File: tb/tb_scc_channel_sequencer.sv
// Randomized bench for scc_channel_sequencer against a frame-level reference model.
module tb_scc_channel_sequencer;

    logic        clk = 1'b0;
    logic        reset;
    logic [2:0]  active;
    logic [4:0]  wave_address;
    logic [11:0] reg_frequency_count;
    logic [3:0]  reg_volume;
    logic        reg_enable, reg_wave_reset, reg_wave_error_en;
    logic        clear_counter_a, clear_counter_b, clear_counter_c, clear_counter_d, clear_counter_e;
    logic        cpu_req, cpu_we, cpu_ack;
    logic [7:0]  cpu_address, cpu_wdata, cpu_rdata;
    logic [6:0]  ram_address;
    logic        ram_we;
    logic [7:0]  ram_wdata, ram_rdata;

    always #5 clk = ~clk;

    scc_channel_sequencer dut (
        .clk(clk), .reset(reset), .active(active), .wave_address(wave_address),
        .reg_frequency_count(reg_frequency_count), .reg_volume(reg_volume),
        .reg_enable(reg_enable), .reg_wave_reset(reg_wave_reset),
        .reg_wave_error_en(reg_wave_error_en),
        .clear_counter_a(clear_counter_a), .clear_counter_b(clear_counter_b),
        .clear_counter_c(clear_counter_c), .clear_counter_d(clear_counter_d),
        .clear_counter_e(clear_counter_e),
        .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_address(cpu_address),
        .cpu_wdata(cpu_wdata), .cpu_rdata(cpu_rdata), .cpu_ack(cpu_ack),
        .ram_address(ram_address), .ram_we(ram_we), .ram_wdata(ram_wdata),
        .ram_rdata(ram_rdata)
    );

    // behavioural wave RAM with one-cycle read latency
    logic [7:0] ram [128];
    logic [7:0] ram_q;
    always @(posedge clk) begin
        if (ram_we) ram[ram_address] <= ram_wdata;
        ram_q <= ram[ram_address];
    end
    assign ram_rdata = ram_q;

    typedef struct packed {
        logic [7:0] addr;
        logic       we;
        logic [7:0] data;
    } txn_t;

    int total = 0;
    int bad = 0;
    int cyc = 0;
    int req_start = 0;
    int last_lat = -1;
    int clr_a_cnt = 0;
    logic [7:0] last_rdata = 8'h00;

    // reference model state
    int          m_slot;
    logic [11:0] m_freq [5];
    logic [3:0]  m_vol [5];
    logic [4:0]  m_en;
    logic [1:0]  m_mode;
    logic [7:0]  m_wave [128];
    bit          m_wvalid [128];
    bit          m_ack, m_read, m_rd_known;
    logic [7:0]  m_rdata;
    logic [4:0]  m_clr;

    txn_t q[$];
    txn_t cur;
    bit   req_on = 1'b0;
    bit   eager = 1'b0;
    bit   kill_on_grant = 1'b0;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    function automatic logic [7:0] m_readback(input logic [7:0] addr);
        int a = int'(addr);
`ifdef SCC_REG_READBACK_EN
        if (a >= 'h80 && a <= 'h89) begin
            if (a % 2 == 1) return {4'hF, m_freq[(a - 'h80) / 2][11:8]};
            return m_freq[(a - 'h80) / 2][7:0];
        end
        if (a >= 'h8A && a <= 'h8E) return {4'hF, m_vol[a - 'h8A]};
        if (a == 'h8F) return {3'b111, m_en};
        if (a == 'hE0) return {6'h3F, m_mode};
`endif
        return (a >= 0) ? 8'hFF : 8'h00;
    endfunction

    task automatic m_reset();
        m_slot = 0;
        for (int i = 0; i < 5; i++) begin
            m_freq[i] = '0;
            m_vol[i] = '0;
        end
        m_en = '0; m_mode = '0; m_ack = 0; m_read = 0; m_rd_known = 0; m_clr = '0;
    endtask

    task automatic m_apply(input txn_t t);
        int a = int'(t.addr);
        if (t.we) begin
            if (a < 'h80) begin
                m_wave[a] = t.data;
                m_wvalid[a] = 1'b1;
            end else if (a <= 'h89) begin
                int ch = (a - 'h80) / 2;
                if (a % 2 == 1) m_freq[ch] = {t.data[3:0], m_freq[ch][7:0]};
                else            m_freq[ch] = {m_freq[ch][11:8], t.data};
                m_clr[ch] = 1'b1;
            end else if (a <= 'h8E) m_vol[a - 'h8A] = t.data[3:0];
            else if (a == 'h8F) m_en = t.data[4:0];
            else if (a == 'hE0) m_mode = t.data[1:0];
        end else begin
            m_read = 1'b1;
            if (a < 'h80) begin
                m_rdata = m_wave[a];
                m_rd_known = m_wvalid[a];
            end else begin
                m_rdata = m_readback(t.addr);
                m_rd_known = 1'b1;
            end
        end
    endtask

    function automatic txn_t rand_txn();
        txn_t t;
        int k = $urandom_range(0, 9);
        t.we = 1'($urandom_range(0, 1));
        t.data = 8'($urandom);
        if (k < 4)       t.addr = 8'($urandom_range(0, 127));
        else if (k < 7)  t.addr = 8'($urandom_range('h80, 'h8F));
        else if (k == 7) t.addr = 8'hE0;
        else             t.addr = 8'($urandom_range('h90, 'hFF));
        return t;
    endfunction

    // one clock: drive at posedge+1, check at posedge+2, advance model at the edge
    task automatic cycle(input bit rst_in);
        bit gnt, do_rst, kill_hit, exp_we;
        logic [6:0] exp_addr;
        if (!req_on && q.size() > 0 && (eager || $urandom_range(0, 2) == 0)) begin
            cur = q.pop_front();
            req_on = 1'b1;
            req_start = cyc;
        end
        cpu_req = req_on;
        if (req_on) begin
            cpu_address = cur.addr; cpu_we = cur.we; cpu_wdata = cur.data;
        end else begin
            cpu_address = 8'($urandom); cpu_we = 1'($urandom); cpu_wdata = 8'($urandom);
        end
        wave_address = 5'($urandom);
        kill_hit = kill_on_grant && m_slot == 5 && req_on;
        do_rst = rst_in || kill_hit;
        reset = do_rst;
        gnt = !do_rst && m_slot == 5 && req_on;
        #1;
        check_val("active", active, m_slot);
        if (m_slot < 4)       exp_addr = {2'(m_slot), wave_address};
        else if (m_slot == 4) exp_addr = {2'd3, wave_address};
        else                  exp_addr = (gnt && !cur.addr[7]) ? cur.addr[6:0] : 7'd0;
        exp_we = gnt && !cur.addr[7] && cur.we;
        check_val("ram_address", ram_address, exp_addr);
        check_val("ram_we", ram_we, exp_we);
        if (exp_we) check_val("ram_wdata", ram_wdata, cur.data);
        check_val("freq", reg_frequency_count, m_slot < 5 ? m_freq[m_slot] : 12'd0);
        check_val("volume", reg_volume, m_slot < 5 ? m_vol[m_slot] : 4'd0);
        check_val("enable", reg_enable, m_slot < 5 ? m_en[m_slot] : 1'b0);
        check_val("mode", {reg_wave_error_en, reg_wave_reset}, m_mode);
        check_val("cpu_ack", cpu_ack, m_ack);
        check_val("clear", {clear_counter_e, clear_counter_d, clear_counter_c,
                            clear_counter_b, clear_counter_a}, m_clr);
        if (m_ack && m_read && m_rd_known) check_val("cpu_rdata", cpu_rdata, m_rdata);
        if (clear_counter_a) clr_a_cnt++;
        if (cpu_ack && req_on) begin
            last_lat = cyc - req_start;
            last_rdata = cpu_rdata;
            req_on = 1'b0;
        end
        if (kill_hit) req_on = 1'b0;
        @(posedge clk);
        cyc++;
        if (do_rst) begin
            m_reset();
        end else begin
            m_slot = (m_slot + 1) % 6;
            m_ack = gnt; m_read = 1'b0; m_rd_known = 1'b0; m_clr = '0;
            if (gnt) m_apply(cur);
        end
        #1;
    endtask

    task automatic run_idle();
        for (int i = 0; i < 200 && (q.size() > 0 || req_on); i++) cycle(1'b0);
        if (q.size() > 0 || req_on) check_val("timeout", 1, 0);
    endtask

    initial begin
        for (int i = 0; i < 128; i++) m_wvalid[i] = 1'b0;
        reset = 1'b1; cpu_req = 1'b0; cpu_we = 1'b0; cpu_address = '0;
        cpu_wdata = '0; wave_address = '0;
        repeat (3) @(posedge clk);
        m_reset();
        #1;
        check_val("rst_active", active, 0);
        check_val("rst_ack", cpu_ack, 0);
        check_val("rst_rdata", cpu_rdata, 0);
        check_val("rst_ram_we", ram_we, 0);
        check_val("rst_freq", reg_frequency_count, 0);

        repeat (60) cycle(1'b0);

        clr_a_cnt = 0;
        q.push_back('{8'h81, 1'b1, 8'h0A});
        q.push_back('{8'h80, 1'b1, 8'h34});
        run_idle();
        while (m_slot != 0) cycle(1'b0);
        #1;
        check_val("freq_a_direct", reg_frequency_count, 12'hA34);
        check_val("clr_a_pulses", clr_a_cnt, 2);

        q.push_back('{8'h65, 1'b1, 8'h7F});
        q.push_back('{8'h65, 1'b0, 8'h00});
        run_idle();
        check_val("wave_readback", last_rdata, 8'h7F);

        q.push_back('{8'h8A, 1'b1, 8'h0C});
        q.push_back('{8'h8A, 1'b0, 8'h00});
        run_idle();
`ifdef SCC_REG_READBACK_EN
        check_val("vol_readback", last_rdata, 8'hFC);
`else
        check_val("vol_readback", last_rdata, 8'hFF);
`endif

        eager = 1'b1;
        while (m_slot != 0) cycle(1'b0);
        q.push_back('{8'h8B, 1'b1, 8'h05});
        run_idle();
        check_val("latency_slot0", last_lat, 6);
        while (m_slot != 5) cycle(1'b0);
        q.push_back('{8'h90, 1'b1, 8'h11});
        run_idle();
        check_val("latency_slot5", last_lat, 1);
        eager = 1'b0;

        kill_on_grant = 1'b1;
        q.push_back('{8'h8F, 1'b1, 8'h1F});
        run_idle();
        kill_on_grant = 1'b0;
        check_val("kill_active", active, 0);
        check_val("kill_enable_a", reg_enable, 0);
        repeat (12) cycle(1'b0);

        for (int i = 0; i < 2500; i++) begin
            if (q.size() == 0 && $urandom_range(0, 3) == 0) q.push_back(rand_txn());
            cycle($urandom_range(0, 299) == 0);
        end
        run_idle();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
